// File: rtl/frac_scale_stepper_pkg.sv
// Shared types, default widths and pad helper for the fractional scale stepper.
package frac_scale_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      RUN    = 2'd2
   } fss_state_t;

   localparam int unsigned FSS_BITWIDTH_DEF  = 10;
   localparam int unsigned FSS_FRACWIDTH_DEF = 16;
   localparam int unsigned FSS_CENTRE_DEF    = 1;

   // Leading blank steps; any odd remainder of the padding lands after the span.
   function automatic logic [31:0] pad_calc(input logic        centre,
                                            input logic [31:0] window,
                                            input logic [31:0] len);
      logic [31:0] diff;
      diff = window - len;
      if (centre && (window > len)) begin
         return diff >> 1;
      end
      return '0;
   endfunction

endpackage

// File: rtl/frac_scale_stepper_seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle, req/ack handshake.
module seq_udiv #(
   parameter int unsigned N = 26
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         ack,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder
);

   localparam int unsigned CW = $clog2(N + 1);

   logic [N-1:0]  quo_q, quo_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          ack_q, ack_d;
   logic [N:0]    partial;
   logic          ge;

   always_comb begin
      partial = {rem_q, quo_q[N-1]};
      ge      = (partial >= {1'b0, div_q});
      quo_d   = quo_q;
      rem_d   = rem_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      if (req) begin
         quo_d  = dividend;
         rem_d  = '0;
         div_d  = divisor;
         cnt_d  = CW'(N);
         busy_d = 1'b1;
      end else if (busy_q) begin
         quo_d = {quo_q[N-2:0], ge};
         rem_d = ge ? N'(partial - {1'b0, div_q}) : partial[N-1:0];
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            ack_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quo_q  <= '0;
         rem_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         ack_q  <= ack_d;
      end
   end

   assign busy      = busy_q;
   assign ack       = ack_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/frac_scale_stepper.sv
// Per-axis fractional source-coordinate stepper with centred letterbox pad.
// Define FRAC_SCALE_STEPPER_ROUND_EN for a round-to-nearest step.
module frac_scale_stepper
   import frac_scale_pkg::*;
#(
   parameter int unsigned BITWIDTH  = FSS_BITWIDTH_DEF,
   parameter int unsigned FRACWIDTH = FSS_FRACWIDTH_DEF,
   parameter int unsigned CENTRE    = FSS_CENTRE_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BITWIDTH-1:0]  src_len,
   input  logic [BITWIDTH-1:0]  dst_len,
   input  logic [BITWIDTH-1:0]  dst_window,
   input  logic                 cfg_req,
   output logic                 cfg_ack,
   output logic                 busy,
   input  logic                 step_reset,
   input  logic                 step_in,
   output logic                 step_out,
   output logic [BITWIDTH-1:0]  whole,
   output logic [FRACWIDTH-1:0] fraction,
   output logic [BITWIDTH-1:0]  advance,
   output logic                 blank
);

   localparam int unsigned ACCW = BITWIDTH + FRACWIDTH;

   fss_state_t          state_q, state_d;
   logic [BITWIDTH-1:0] src_q, src_d;
   logic [BITWIDTH-1:0] dst_q, dst_d;
   logic [BITWIDTH-1:0] pad_len_q, pad_len_d;
   logic                zero_len_q, zero_len_d;
   logic [ACCW-1:0]     step_q, step_d;
   logic [ACCW-1:0]     acc_q, acc_d;
   logic [BITWIDTH-1:0] cnt_q, cnt_d;
   logic [BITWIDTH-1:0] pad_cnt_q, pad_cnt_d;
   logic                cfg_ack_q, cfg_ack_d;
   logic                step_out_q, step_out_d;
   logic [BITWIDTH-1:0] whole_q, whole_d;
   logic [FRACWIDTH-1:0] frac_q, frac_d;
   logic [BITWIDTH-1:0] adv_q, adv_d;
   logic                blank_q, blank_d;

   logic                div_req;
   logic                div_ack;
   logic                div_busy_unused;
   logic [ACCW-1:0]     div_quo;
   logic [ACCW-1:0]     div_rem_unused;
   logic [ACCW-1:0]     dividend;
   logic [ACCW:0]       acc_sum;
   logic [ACCW-1:0]     acc_next;
   logic [BITWIDTH-1:0] acc_int;
   logic [BITWIDTH-1:0] next_int;

`ifdef FRAC_SCALE_STEPPER_ROUND_EN
   assign dividend = {src_len, {FRACWIDTH{1'b0}}} + ACCW'(dst_len >> 1);
`else
   assign dividend = {src_len, {FRACWIDTH{1'b0}}};
`endif

   seq_udiv #(.N(ACCW)) u_div (
      .clk       (clk),
      .reset     (reset),
      .req       (div_req),
      .dividend  (dividend),
      .divisor   (ACCW'(dst_len)),
      .busy      (div_busy_unused),
      .ack       (div_ack),
      .quotient  (div_quo),
      .remainder (div_rem_unused)
   );

   // Accumulator saturates instead of wrapping so the limit guard always trips.
   assign acc_sum  = {1'b0, acc_q} + {1'b0, step_q};
   assign acc_next = acc_sum[ACCW] ? '1 : acc_sum[ACCW-1:0];
   assign acc_int  = acc_q[ACCW-1:FRACWIDTH];
   assign next_int = acc_next[ACCW-1:FRACWIDTH];

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      pad_len_d  = pad_len_q;
      zero_len_d = zero_len_q;
      step_d     = step_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      pad_cnt_d  = pad_cnt_q;
      cfg_ack_d  = cfg_ack_q;
      step_out_d = 1'b0;
      whole_d    = whole_q;
      frac_d     = frac_q;
      adv_d      = adv_q;
      blank_d    = blank_q;
      div_req    = 1'b0;

      if (cfg_req) begin
         state_d    = DIVIDE;
         src_d      = src_len;
         dst_d      = dst_len;
         pad_len_d  = BITWIDTH'(pad_calc(CENTRE != 0, 32'(dst_window), 32'(dst_len)));
         zero_len_d = (dst_len == '0);
         cfg_ack_d  = 1'b0;
         div_req    = 1'b1;
      end else begin
         case (state_q)
            DIVIDE: begin
               if (zero_len_q || div_ack) begin
                  state_d   = RUN;
                  cfg_ack_d = 1'b1;
                  step_d    = zero_len_q ? '1 : div_quo;
                  acc_d     = '0;
                  cnt_d     = '0;
                  pad_cnt_d = pad_len_q;
               end
            end
            RUN: begin
               if (step_reset) begin
                  acc_d     = '0;
                  cnt_d     = '0;
                  pad_cnt_d = pad_len_q;
               end else if (step_in) begin
                  step_out_d = 1'b1;
                  if (pad_cnt_q != '0) begin
                     pad_cnt_d = pad_cnt_q - BITWIDTH'(1);
                     blank_d   = 1'b1;
                     whole_d   = '0;
                     frac_d    = '0;
                     adv_d     = '0;
                  end else if ((cnt_q >= dst_q) || (acc_int >= src_q)) begin
                     blank_d = 1'b1;
                     whole_d = acc_int;
                     frac_d  = '0;
                     adv_d   = '0;
                  end else begin
                     blank_d = 1'b0;
                     whole_d = acc_int;
                     frac_d  = acc_q[FRACWIDTH-1:0];
                     adv_d   = next_int - acc_int;
                     acc_d   = acc_next;
                     cnt_d   = cnt_q + BITWIDTH'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         pad_len_q  <= '0;
         zero_len_q <= 1'b0;
         step_q     <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         pad_cnt_q  <= '0;
         cfg_ack_q  <= 1'b0;
         step_out_q <= 1'b0;
         whole_q    <= '0;
         frac_q     <= '0;
         adv_q      <= '0;
         blank_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         pad_len_q  <= pad_len_d;
         zero_len_q <= zero_len_d;
         step_q     <= step_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         pad_cnt_q  <= pad_cnt_d;
         cfg_ack_q  <= cfg_ack_d;
         step_out_q <= step_out_d;
         whole_q    <= whole_d;
         frac_q     <= frac_d;
         adv_q      <= adv_d;
         blank_q    <= blank_d;
      end
   end

   assign cfg_ack  = cfg_ack_q;
   assign busy     = (state_q == DIVIDE);
   assign step_out = step_out_q;
   assign whole    = whole_q;
   assign fraction = frac_q;
   assign advance  = adv_q;
   assign blank    = blank_q;

endmodule

// File: tb/tb_frac_scale_stepper.sv
// Directed self-checking bench for frac_scale_stepper (W=10, F=16, CENTRE=1).
module tb_frac_scale_stepper;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  src_len, dst_len, dst_window;
   logic        cfg_req, step_reset, step_in;
   logic        cfg_ack, busy, step_out, blank;
   logic [9:0]  whole, advance;
   logic [15:0] fraction;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   frac_scale_stepper #(
      .BITWIDTH  (10),
      .FRACWIDTH (16),
      .CENTRE    (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .src_len    (src_len),
      .dst_len    (dst_len),
      .dst_window (dst_window),
      .cfg_req    (cfg_req),
      .cfg_ack    (cfg_ack),
      .busy       (busy),
      .step_reset (step_reset),
      .step_in    (step_in),
      .step_out   (step_out),
      .whole      (whole),
      .fraction   (fraction),
      .advance    (advance),
      .blank      (blank)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_cfg(input int unsigned s, input int unsigned d, input int unsigned w,
                         output int lat);
      @(negedge clk);
      src_len    = 10'(s);
      dst_len    = 10'(d);
      dst_window = 10'(w);
      cfg_req    = 1'b1;
      @(posedge clk);
      #1;
      cfg_req = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (cfg_ack) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_step(input logic with_reset, output logic so, output logic bl,
                          output logic [9:0] wh, output logic [15:0] fr, output logic [9:0] ad);
      @(negedge clk);
      step_in    = 1'b1;
      step_reset = with_reset;
      @(posedge clk);
      #1;
      step_in    = 1'b0;
      step_reset = 1'b0;
      so = step_out;
      bl = blank;
      wh = whole;
      fr = fraction;
      ad = advance;
   endtask

   initial begin
      int          lat;
      logic        so, bl;
      logic [9:0]  wh, ad;
      logic [15:0] fr;
      int unsigned exp_step, acc;
      int unsigned up_w[4]  = '{0, 0, 1, 1};
      int unsigned up_f[4]  = '{0, 'h8000, 0, 'h8000};
      int unsigned up_a[4]  = '{0, 1, 0, 1};
      int unsigned dn_w[4]  = '{0, 1, 2, 3};
      int unsigned dn_f[4]  = '{0, 'h5555, 'hAAAA, 'hFFFF};
      int unsigned dn_a[4]  = '{1, 1, 1, 2};

      reset = 1'b1;
      src_len = '0; dst_len = '0; dst_window = '0;
      cfg_req = 1'b0; step_reset = 1'b0; step_in = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_ack", cfg_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stepout", step_out, 0);
      chk("rst_whole", whole, 0);
      chk("rst_frac", fraction, 0);
      chk("rst_adv", advance, 0);
      chk("rst_blank", blank, 1);
      @(negedge clk);
      reset = 1'b0;

      do_step(1'b0, so, bl, wh, fr, ad);
      chk("idle_step_ignored", so, 0);

      // Upscale 320 -> 640, no padding (window equals span)
      do_cfg(320, 640, 640, lat);
      chk("up_latency", lat, 27);
      for (int i = 0; i < 4; i++) begin
         do_step(1'b0, so, bl, wh, fr, ad);
         chk($sformatf("up%0d_so", i), so, 1);
         chk($sformatf("up%0d_blank", i), bl, 0);
         chk($sformatf("up%0d_whole", i), wh, up_w[i]);
         chk($sformatf("up%0d_frac", i), fr, up_f[i]);
         chk($sformatf("up%0d_adv", i), ad, up_a[i]);
      end

      do_step(1'b1, so, bl, wh, fr, ad);
      chk("reset_wins_so", so, 0);
      do_step(1'b0, so, bl, wh, fr, ad);
      chk("after_sreset_whole", wh, 0);
      chk("after_sreset_frac", fr, 0);

      // Downscale 640 -> 480, step 0x15555
      do_cfg(640, 480, 480, lat);
      chk("dn_latency", lat, 27);
      for (int i = 0; i < 4; i++) begin
         do_step(1'b0, so, bl, wh, fr, ad);
         chk($sformatf("dn%0d_blank", i), bl, 0);
         chk($sformatf("dn%0d_whole", i), wh, dn_w[i]);
         chk($sformatf("dn%0d_frac", i), fr, dn_f[i]);
         chk($sformatf("dn%0d_adv", i), ad, dn_a[i]);
      end

      // 1 -> 3: three active steps then blank
`ifdef FRAC_SCALE_STEPPER_ROUND_EN
      exp_step = ((1 << 16) + (3 >> 1)) / 3;
`else
      exp_step = (1 << 16) / 3;
`endif
      do_cfg(1, 3, 3, lat);
      chk("rnd_latency", lat, 27);
      for (int i = 0; i < 4; i++) begin
         acc = i * exp_step;
         do_step(1'b0, so, bl, wh, fr, ad);
         chk($sformatf("rnd%0d_blank", i), bl, (i == 3) ? 1 : 0);
         chk($sformatf("rnd%0d_frac", i), fr, (i == 3) ? 0 : (acc & 'hFFFF));
      end

      // Centred 320 -> 640 in a 720 window: 40 pad, 640 active, 40 trailing blank
      do_cfg(320, 640, 720, lat);
      chk("ctr_latency", lat, 27);
      for (int i = 0; i < 720; i++) begin
         do_step(1'b0, so, bl, wh, fr, ad);
         chk($sformatf("ctr%0d_so", i), so, 1);
         if (i < 40 || i >= 680) begin
            chk($sformatf("ctr%0d_blank", i), bl, 1);
         end else begin
            chk($sformatf("ctr%0d_blank", i), bl, 0);
            chk($sformatf("ctr%0d_whole", i), wh, (i - 40) / 2);
         end
      end

      // Mid-span cfg_req, steps ignored during divide, restart 10 cycles in
      @(negedge clk);
      src_len = 10'd320; dst_len = 10'd640; dst_window = 10'd640;
      cfg_req = 1'b1;
      @(posedge clk);
      #1;
      cfg_req = 1'b0;
      chk("midspan_ack_drop", cfg_ack, 0);
      chk("midspan_busy", busy, 1);
      for (int i = 0; i < 9; i++) begin
         do_step(1'b0, so, bl, wh, fr, ad);
         chk($sformatf("div_step%0d_ignored", i), so, 0);
      end
      do_cfg(640, 480, 480, lat);
      chk("restart_latency", lat, 27);
      do_step(1'b0, so, bl, wh, fr, ad);
      do_step(1'b0, so, bl, wh, fr, ad);
      chk("restart_frac", fr, 'h5555);

      // Zero destination length
      do_cfg(320, 0, 0, lat);
      chk("zero_latency", lat, 1);
      for (int i = 0; i < 4; i++) begin
         do_step(1'b0, so, bl, wh, fr, ad);
         chk($sformatf("zero%0d_so", i), so, 1);
         chk($sformatf("zero%0d_blank", i), bl, 1);
      end

      // Async reset while running
      do_cfg(320, 640, 640, lat);
      chk("prerst_latency", lat, 27);
      do_step(1'b0, so, bl, wh, fr, ad);
      do_step(1'b0, so, bl, wh, fr, ad);
      chk("prerst_frac", fr, 'h8000);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_ack", cfg_ack, 0);
      chk("arst_busy", busy, 0);
      chk("arst_frac", fraction, 0);
      chk("arst_blank", blank, 1);
      @(negedge clk);
      reset = 1'b0;
      do_step(1'b0, so, bl, wh, fr, ad);
      chk("arst_step_ignored", so, 0);
      chk("arst_ack_stays_low", cfg_ack, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
